uart_frame_ctrl: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 23 ++
 rtl/frame_timeout_ctr.sv | 33 +++
 rtl/uart_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame controller: sync/command bytes,
// error codes and the frame-parser state encoding.
// Contents: SYNC_BYTE, CMD_K, CMD_X, ERR_* codes, state_t.
package uart_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_K     = 8'h01;
    localparam logic [7:0] CMD_X     = 8'h02;

    localparam logic [1:0] ERR_BADCMD  = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte idle counter; flags expiry when it sits at TIMEOUT_CLKS-1.
// Latency: expired is combinational from the count register.
// Backpressure: none; counts while enable=1, held at zero otherwise.
// Ports: clk, rst (async, active-high), clear (restart from zero),
//        enable (count while high), expired (terminal count reached).
module frame_timeout_ctr #(
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CLKS);
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CLKS - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != TERM) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TERM);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses sync/cmd/payload/checksum frames from the UART byte stream into K/X payloads.
// Latency: k_valid/x_valid rise one clock after the checksum byte strobe.
// Backpressure: payload held in HOLD until ready; bytes arriving meanwhile are dropped as OVERRUN.
// Ports: clk, rst (async, active-high); s_valid/s_data byte input;
//        k_valid/k_ready/k_data and x_valid/x_ready/x_data payload outputs;
//        err_pulse/err_code error strobe; busy (parser not idle).
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int BYTES_K      = 4,
    parameter int BYTES_X      = 2,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    output logic                 k_valid,
    input  logic                 k_ready,
    output logic [8*BYTES_K-1:0] k_data,
    output logic                 x_valid,
    input  logic                 x_ready,
    output logic [8*BYTES_X-1:0] x_data,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam int BMAX = (BYTES_K > BYTES_X) ? BYTES_K : BYTES_X;
    localparam int CW   = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(BYTES_K - 1);
    localparam logic [CW-1:0] X_LAST = CW'(BYTES_X - 1);

    state_t              state;
    logic                is_k;
    logic [CW-1:0]       cnt;
    logic [7:0]          csum;
    logic [8*BMAX-1:0]   pay_buf;
    logic                expired;
    logic                tmo_en;
    logic                handshake;

    assign tmo_en    = (state == ST_CMD) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    assign handshake = (k_valid && k_ready) || (x_valid && x_ready);

    // Every in-frame state is entered either from a state where the counter is
    // disabled (and therefore zero) or on a byte, so clearing on bytes alone
    // also covers the clear-on-state-entry requirement.
    frame_timeout_ctr #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (s_valid),
        .enable  (tmo_en),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            is_k      <= 1'b0;
            cnt       <= '0;
            csum      <= '0;
            pay_buf   <= '0;
            k_valid   <= 1'b0;
            k_data    <= '0;
            x_valid   <= 1'b0;
            x_data    <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
            busy      <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            err_code  <= '0;

            case (state)
                ST_IDLE: begin
                    if (s_valid && s_data == SYNC_BYTE) begin
                        state <= ST_CMD;
                        busy  <= 1'b1;
                    end
                end

                ST_CMD: begin
                    if (s_valid) begin
                        csum <= s_data;
                        cnt  <= '0;
                        if (s_data == CMD_K) begin
                            is_k  <= 1'b1;
                            state <= ST_PAYLOAD;
                        end else if (s_data == CMD_X) begin
                            is_k  <= 1'b0;
                            state <= ST_PAYLOAD;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_BADCMD;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (expired) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end

                ST_PAYLOAD: begin
                    if (s_valid) begin
                        // Byte n lands in lane n so the first byte ends up in [7:0]
                        // for either payload length.
                        for (int i = 0; i < BMAX; i++) begin
                            if (cnt == CW'(i)) begin
                                pay_buf[8*i +: 8] <= s_data;
                            end
                        end
                        csum <= csum + s_data;
                        if (cnt == (is_k ? K_LAST : X_LAST)) begin
                            state <= ST_CSUM;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (expired) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end

                ST_CSUM: begin
                    if (s_valid) begin
                        if (s_data == csum) begin
                            if (is_k) begin
                                k_data  <= pay_buf[8*BYTES_K-1:0];
                                k_valid <= 1'b1;
                            end else begin
                                x_data  <= pay_buf[8*BYTES_X-1:0];
                                x_valid <= 1'b1;
                            end
                            state <= ST_HOLD;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_CSUM;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (expired) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (handshake) begin
                        k_valid <= 1'b0;
                        x_valid <= 1'b0;
                        // A byte coinciding with the handshake is treated as an IDLE byte.
                        if (s_valid && s_data == SYNC_BYTE) begin
                            state <= ST_CMD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (s_valid) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_OVERRUN;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
module tb_uart_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        k_valid;
    logic        k_ready;
    logic [31:0] k_data;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] x_data;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .BYTES_K      (4),
        .BYTES_X      (2),
        .TIMEOUT_CLKS (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .k_valid   (k_valid),
        .k_ready   (k_ready),
        .k_data    (k_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one byte, which the next posedge samples,
    // and returns at the following negedge with the strobe removed.
    task automatic send_byte(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        k_ready = 1'b1;
        x_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_k_valid", 32'(k_valid), 32'd0);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_k_data", k_data, 32'd0);
        check("rst_x_data", 32'(x_data), 32'd0);
        check("rst_err", 32'({err_pulse, err_code}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: junk byte ignored, K frame with ready high
        send_byte(8'h3C);
        check("t1_junk_busy", 32'(busy), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        check("t1_pre_valid", 32'(k_valid), 32'd0);
        send_byte(8'hAB);
        check("t1_k_valid", 32'(k_valid), 32'd1);
        check("t1_k_data", k_data, 32'h44332211);
        check("t1_no_err", 32'(err_pulse), 32'd0);
        check("t1_x_valid", 32'(x_valid), 32'd0);
        @(negedge clk);
        check("t1_k_drop", 32'(k_valid), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: X frame held for 100 cycles
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h32);
        for (int i = 0; i < 100; i++) begin
            check("t2_hold_valid", 32'(x_valid), 32'd1);
            check("t2_hold_data", 32'(x_data), 32'h2010);
            @(negedge clk);
        end
        check("t2_hold_busy", 32'(busy), 32'd1);
        x_ready = 1'b1;
        @(negedge clk);
        check("t2_x_drop", 32'(x_valid), 32'd0);
        check("t2_busy_after", 32'(busy), 32'd0);
        x_ready = 1'b0;

        // 3: bad checksum on X frame
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h33);
        check("t3_err_pulse", 32'(err_pulse), 32'd1);
        check("t3_err_code", 32'(err_code), 32'd1);
        check("t3_x_valid", 32'(x_valid), 32'd0);
        check("t3_x_data", 32'(x_data), 32'h2010);
        @(negedge clk);
        check("t3_err_one_cycle", 32'(err_pulse), 32'd0);

        // 4: bad command, then good K frame
        send_byte(8'hA5);
        send_byte(8'h07);
        check("t4_err_pulse", 32'(err_pulse), 32'd1);
        check("t4_err_code", 32'(err_code), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h0B);
        check("t4_k_valid", 32'(k_valid), 32'd1);
        check("t4_k_data", k_data, 32'h04030201);
        @(negedge clk);
        check("t4_k_drop", 32'(k_valid), 32'd0);

        // 5: timeout exactly 64 clocks after the last byte
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        repeat (63) @(negedge clk);
        check("t5_no_early_tmo", 32'(err_pulse), 32'd0);
        check("t5_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        check("t5_tmo_pulse", 32'(err_pulse), 32'd1);
        check("t5_tmo_code", 32'(err_code), 32'd2);
        check("t5_tmo_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("t5_tmo_one_cycle", 32'(err_pulse), 32'd0);

        // 5b: byte lands on the terminal count and wins
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        repeat (63) @(negedge clk);
        send_byte(8'h22);
        check("t5b_no_tmo", 32'(err_pulse), 32'd0);
        check("t5b_busy", 32'(busy), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'hAB);
        check("t5b_k_valid", 32'(k_valid), 32'd1);
        check("t5b_k_data", k_data, 32'h44332211);
        @(negedge clk);

        // 6: overrun while holding a K payload
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        k_ready = 1'b0;
        send_byte(8'h0B);
        check("t6_hold_valid", 32'(k_valid), 32'd1);
        send_byte(8'h55);
        check("t6_ovr_pulse", 32'(err_pulse), 32'd1);
        check("t6_ovr_code", 32'(err_code), 32'd3);
        check("t6_ovr_k_valid", 32'(k_valid), 32'd1);
        check("t6_ovr_k_data", k_data, 32'h04030201);

        // handshake and sync byte in the same cycle starts a new frame
        k_ready = 1'b1;
        send_byte(8'hA5);
        check("t6_hs_k_drop", 32'(k_valid), 32'd0);
        check("t6_hs_no_err", 32'(err_pulse), 32'd0);
        check("t6_hs_busy", 32'(busy), 32'd1);
        send_byte(8'h02);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'hBD);
        check("t6_x_valid", 32'(x_valid), 32'd1);
        check("t6_x_data", 32'(x_data), 32'h6655);
        check("t6_k_excl", 32'(k_valid), 32'd0);
        x_ready = 1'b1;
        @(negedge clk);
        check("t6_x_drop", 32'(x_valid), 32'd0);
        x_ready = 1'b0;

        // reset mid-payload
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        check("t6_rst_k_valid", 32'(k_valid), 32'd0);
        check("t6_rst_k_data", k_data, 32'd0);
        check("t6_rst_x_data", 32'(x_data), 32'd0);
        check("t6_rst_err", 32'({err_pulse, err_code}), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h0B);
        check("t6_post_rst_valid", 32'(k_valid), 32'd1);
        check("t6_post_rst_data", k_data, 32'h04030201);
        @(negedge clk);
        check("t6_post_rst_drop", 32'(k_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
